// File: rtl/pipelined_add_sub_if.sv
// Operand/result handshake bundle for pipelined_add_sub.
// The master side drives operands and the result-ready signal; the slave side is the adder.
interface pipelined_add_sub_if #(
  parameter int WIDTH = 32
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] A_i;
  logic [WIDTH-1:0] B_i;
  logic             sub_i;
  logic             c_in;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] S_o;
  logic             c_out;
  logic             ovf_o;

  modport master (
    output in_valid_i, A_i, B_i, sub_i, c_in, out_ready_i,
    input  in_ready_o, out_valid_o, S_o, c_out, ovf_o
  );

  modport slave (
    input  in_valid_i, A_i, B_i, sub_i, c_in, out_ready_i,
    output in_ready_o, out_valid_o, S_o, c_out, ovf_o
  );
endinterface

// File: rtl/pipelined_add_sub.sv
// Skewed add/subtract pipeline: one CHUNK-bit slice resolved per stage, carry registered between
// stages, whole pipe advancing together under valid/ready backpressure.
module pipelined_add_sub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input logic                clk,
  input logic                rst,
  pipelined_add_sub_if.slave bus
);
  localparam int NSTAGES = WIDTH / CHUNK;

  if (WIDTH % CHUNK != 0) begin : gBadConfig
    $error("pipelined_add_sub: WIDTH must be a multiple of CHUNK");
  end

  logic             adv;
  logic             outValid_q, outValid_d;
  logic             cOut_q, cOut_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             lastCarry;
  logic             msbCarry;

  assign adv            = bus.out_ready_i | ~outValid_q;
  assign bus.in_ready_o = adv;

  // Stage k sees the operand bits not yet consumed, with its own slice in the low CHUNK bits.
  // Stage 0 is fed straight from the input port; later stages from the previous boundary registers.
  for (genvar k = 0; k < NSTAGES; k++) begin : gStage
    localparam int LO  = k * CHUNK;
    localparam int OPW = WIDTH - LO;

    logic                validIn;
    logic                subIn;
    logic                carryIn;
    logic [OPW-1:0]      opA;
    logic [OPW-1:0]      opB;
    logic [CHUNK:0]      sliceSum;
    logic [LO+CHUNK-1:0] sumAcc;

    assign sliceSum = {1'b0, opA[CHUNK-1:0]} + {1'b0, opB[CHUNK-1:0]} + {{CHUNK{1'b0}}, carryIn};

    if (k == 0) begin : gEntry
      // Subtraction is A + ~B + ~borrow, so the inversion happens once, at the entry.
      assign validIn = bus.in_valid_i;
      assign subIn   = bus.sub_i;
      assign carryIn = bus.sub_i ^ bus.c_in;
      assign opA     = bus.A_i;
      assign opB     = bus.sub_i ? ~bus.B_i : bus.B_i;
      assign sumAcc  = sliceSum[CHUNK-1:0];
    end else begin : gBoundary
      logic [LO-1:0] sumLow_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          validIn  <= 1'b0;
          subIn    <= 1'b0;
          carryIn  <= 1'b0;
          opA      <= '0;
          opB      <= '0;
          sumLow_q <= '0;
        end else if (adv) begin
          validIn  <= gStage[k-1].validIn;
          subIn    <= gStage[k-1].subIn;
          carryIn  <= gStage[k-1].sliceSum[CHUNK];
          opA      <= gStage[k-1].opA[OPW+CHUNK-1:CHUNK];
          opB      <= gStage[k-1].opB[OPW+CHUNK-1:CHUNK];
          sumLow_q <= gStage[k-1].sumAcc;
        end
      end

      assign sumAcc = {sliceSum[CHUNK-1:0], sumLow_q};
    end
  end

  // Signed overflow: carry into the MSB differs from carry out of it.
  assign lastCarry = gStage[NSTAGES-1].sliceSum[CHUNK];
  assign msbCarry  = gStage[NSTAGES-1].opA[CHUNK-1] ^ gStage[NSTAGES-1].opB[CHUNK-1] ^
                     gStage[NSTAGES-1].sliceSum[CHUNK-1];

  assign outValid_d = gStage[NSTAGES-1].validIn;
  assign sum_d      = gStage[NSTAGES-1].sumAcc;
  assign cOut_d     = gStage[NSTAGES-1].subIn ^ lastCarry;
  assign ovf_d      = msbCarry ^ lastCarry;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outValid_q <= 1'b0;
      sum_q      <= '0;
      cOut_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else if (adv) begin
      outValid_q <= outValid_d;
      sum_q      <= sum_d;
      cOut_q     <= cOut_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bus.out_valid_o = outValid_q;
  assign bus.S_o         = sum_q;
  assign bus.c_out       = cOut_q;
  assign bus.ovf_o       = ovf_q;
endmodule

// File: tb/tb_pipelined_add_sub.sv
// Self-checking bench for pipelined_add_sub: directed edge cases, random backpressure,
// asynchronous reset flush and a sweep over several WIDTH/CHUNK configurations.
module tb_pipelined_add_sub;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pipelined_add_sub_if #(.WIDTH(32)) bus0 ();
  pipelined_add_sub_if #(.WIDTH(32)) bus1 ();
  pipelined_add_sub_if #(.WIDTH(32)) bus2 ();
  pipelined_add_sub_if #(.WIDTH(64)) bus3 ();

  pipelined_add_sub #(.WIDTH(32), .CHUNK(8))  dut0 (.clk(clk), .rst(rst), .bus(bus0));
  pipelined_add_sub #(.WIDTH(32), .CHUNK(32)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  pipelined_add_sub #(.WIDTH(32), .CHUNK(4))  dut2 (.clk(clk), .rst(rst), .bus(bus2));
  pipelined_add_sub #(.WIDTH(64), .CHUNK(16)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  localparam int LAT0 = 4;

  typedef struct {
    logic [63:0] s;
    logic        co;
    logic        ov;
    int          age;
  } beat_t;

  beat_t inflight[$];
  int    checks = 0;
  int    errors = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference: exact integer arithmetic, signed overflow judged by range of the true result.
  function automatic void refModel(input int w, input logic [63:0] a, input logic [63:0] b,
                                   input logic sub, input logic cin,
                                   output logic [63:0] s, output logic co, output logic ov);
    logic [65:0]        ua, ub, ur, pw;
    logic [63:0]        mask;
    logic signed [65:0] sa, sb, sr, cinExt, hi, lo;
    pw     = 66'd1 << w;
    mask   = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    ua     = {2'b00, a & mask};
    ub     = {2'b00, b & mask};
    sa     = $signed(a[w-1] ? ua - pw : ua);
    sb     = $signed(b[w-1] ? ub - pw : ub);
    cinExt = $signed({65'd0, cin});
    hi     = $signed(pw >> 1) - 66'sd1;
    lo     = -$signed(pw >> 1);
    if (sub) begin
      ur = ua - ub - {65'd0, cin};
      co = ur[65];
      sr = sa - sb - cinExt;
    end else begin
      ur = ua + ub + {65'd0, cin};
      co = ur[w];
      sr = sa + sb + cinExt;
    end
    s  = ur[63:0] & mask;
    ov = (sr > hi) || (sr < lo);
  endfunction

  function automatic logic modelOutValid();
    return (inflight.size() > 0) && (inflight[0].age == LAT0);
  endfunction

  function automatic logic [63:0] edgeValue();
    case ($urandom_range(0, 4))
      0:       return 64'h0;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_8000_0000;
      3:       return 64'h7FFF_FFFF_7FFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // One cycle on dut0: drive at the falling edge, update the model at the rising edge, check after.
  task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] b,
                               input logic s, input logic ci, input logic rdy);
    logic        advExp;
    logic [63:0] es;
    logic        eco, eov;
    beat_t       nb;
    bus0.in_valid_i  = v;
    bus0.A_i         = a;
    bus0.B_i         = b;
    bus0.sub_i       = s;
    bus0.c_in        = ci;
    bus0.out_ready_i = rdy;
    advExp = rdy | ~modelOutValid();
    #1;
    checkOutput("in_ready", {63'd0, bus0.in_ready_o}, {63'd0, advExp});
    @(posedge clk);
    if (advExp) begin
      if (modelOutValid()) void'(inflight.pop_front());
      foreach (inflight[i]) inflight[i].age++;
      if (v) begin
        refModel(32, {32'd0, a}, {32'd0, b}, s, ci, es, eco, eov);
        nb.s   = es;
        nb.co  = eco;
        nb.ov  = eov;
        nb.age = 1;
        inflight.push_back(nb);
      end
    end
    @(negedge clk);
    checkOutput("out_valid", {63'd0, bus0.out_valid_o}, {63'd0, modelOutValid()});
    if (modelOutValid()) begin
      checkOutput("S", {32'd0, bus0.S_o}, inflight[0].s);
      checkOutput("c_out", {63'd0, bus0.c_out}, {63'd0, inflight[0].co});
      checkOutput("ovf", {63'd0, bus0.ovf_o}, {63'd0, inflight[0].ov});
    end
  endtask

  initial begin
    int          accepted;
    logic        rdy;
    logic [63:0] va, vb;
    logic        vs, vc;
    logic [63:0] e1s, e2s, e3s;
    logic        e1c, e1o, e2c, e2o, e3c, e3o;
    int          seen1, seen2, seen3;

    rst = 1'b1;
    bus0.in_valid_i = 1'b0; bus0.A_i = '0; bus0.B_i = '0; bus0.sub_i = 1'b0; bus0.c_in = 1'b0;
    bus0.out_ready_i = 1'b1;
    bus1.in_valid_i = 1'b0; bus1.A_i = '0; bus1.B_i = '0; bus1.sub_i = 1'b0; bus1.c_in = 1'b0;
    bus1.out_ready_i = 1'b1;
    bus2.in_valid_i = 1'b0; bus2.A_i = '0; bus2.B_i = '0; bus2.sub_i = 1'b0; bus2.c_in = 1'b0;
    bus2.out_ready_i = 1'b1;
    bus3.in_valid_i = 1'b0; bus3.A_i = '0; bus3.B_i = '0; bus3.sub_i = 1'b0; bus3.c_in = 1'b0;
    bus3.out_ready_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_out_valid", {63'd0, bus0.out_valid_o}, 64'd0);
    checkOutput("reset_S", {32'd0, bus0.S_o}, 64'd0);
    checkOutput("reset_c_out", {63'd0, bus0.c_out}, 64'd0);
    checkOutput("reset_ovf", {63'd0, bus0.ovf_o}, 64'd0);
    checkOutput("reset_out_valid_w64", {63'd0, bus3.out_valid_o}, 64'd0);
    rst = 1'b0;

    // Directed edge cases, issued back to back.
    applyStimulus(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'd5, 32'd7, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'd7, 32'd5, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, $urandom, $urandom, 1'b1, 1'b1, 1'b1);

    // Random back-to-back traffic with a randomly stalling consumer.
    accepted = 0;
    for (int cyc = 0; cyc < 1000 && accepted < 64; cyc++) begin
      rdy = 1'($urandom_range(0, 1));
      if (rdy | ~modelOutValid()) accepted++;
      applyStimulus(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rdy);
    end
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, $urandom, $urandom, 1'b0, 1'b0, 1'b1);

    // Fill the pipe against a stalled consumer, then reset asynchronously mid-cycle.
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, $urandom, $urandom, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_out_valid", {63'd0, bus0.out_valid_o}, 64'd0);
    checkOutput("async_rst_S", {32'd0, bus0.S_o}, 64'd0);
    checkOutput("async_rst_c_out", {63'd0, bus0.c_out}, 64'd0);
    checkOutput("async_rst_ovf", {63'd0, bus0.ovf_o}, 64'd0);
    checkOutput("async_rst_in_ready", {63'd0, bus0.in_ready_o}, 64'd1);
    inflight.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, $urandom, $urandom, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, $urandom, $urandom, 1'b0, 1'b0, 1'b1);

    // Configuration sweep: one beat at a time, latency measured per instance.
    for (int n = 0; n < 16; n++) begin
      va = edgeValue();
      vb = edgeValue();
      vs = 1'($urandom_range(0, 1));
      vc = 1'($urandom_range(0, 1));
      refModel(32, va, vb, vs, vc, e1s, e1c, e1o);
      refModel(32, va, vb, vs, vc, e2s, e2c, e2o);
      refModel(64, va, vb, vs, vc, e3s, e3c, e3o);
      bus1.A_i = va[31:0]; bus1.B_i = vb[31:0]; bus1.sub_i = vs; bus1.c_in = vc; bus1.in_valid_i = 1'b1;
      bus2.A_i = va[31:0]; bus2.B_i = vb[31:0]; bus2.sub_i = vs; bus2.c_in = vc; bus2.in_valid_i = 1'b1;
      bus3.A_i = va;       bus3.B_i = vb;       bus3.sub_i = vs; bus3.c_in = vc; bus3.in_valid_i = 1'b1;
      seen1 = 0;
      seen2 = 0;
      seen3 = 0;
      for (int c = 1; c <= 10; c++) begin
        @(posedge clk);
        #1;
        bus1.in_valid_i = 1'b0;
        bus2.in_valid_i = 1'b0;
        bus3.in_valid_i = 1'b0;
        if (bus1.out_valid_o && seen1 == 0) begin
          seen1 = c;
          checkOutput("w32c32_S", {32'd0, bus1.S_o}, e1s);
          checkOutput("w32c32_c_out", {63'd0, bus1.c_out}, {63'd0, e1c});
          checkOutput("w32c32_ovf", {63'd0, bus1.ovf_o}, {63'd0, e1o});
        end
        if (bus2.out_valid_o && seen2 == 0) begin
          seen2 = c;
          checkOutput("w32c4_S", {32'd0, bus2.S_o}, e2s);
          checkOutput("w32c4_c_out", {63'd0, bus2.c_out}, {63'd0, e2c});
          checkOutput("w32c4_ovf", {63'd0, bus2.ovf_o}, {63'd0, e2o});
        end
        if (bus3.out_valid_o && seen3 == 0) begin
          seen3 = c;
          checkOutput("w64c16_S", bus3.S_o, e3s);
          checkOutput("w64c16_c_out", {63'd0, bus3.c_out}, {63'd0, e3c});
          checkOutput("w64c16_ovf", {63'd0, bus3.ovf_o}, {63'd0, e3o});
        end
      end
      checkOutput("w32c32_latency", 64'(seen1), 64'd1);
      checkOutput("w32c4_latency", 64'(seen2), 64'd8);
      checkOutput("w64c16_latency", 64'(seen3), 64'd4);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
